// File: rtl/note_sequencer_if.sv
// Control, ROM and note-output signals shared between the sequencer and its surroundings.
// master is the sequencer side; slave is the level controller / ROM / scroller side.
interface note_sequencer_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4
) ();
  logic                  start;
  logic                  pause;
  logic                  beat_tick;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_note;
  logic [DATA_WIDTH-1:0] note_out;
  logic                  note_valid;
  logic [ADDR_WIDTH-1:0] note_idx;
  logic                  busy;
  logic                  done;
  logic                  underrun;

  modport master (
    input  start, pause, beat_tick, rom_note,
    output rom_addr, note_out, note_valid, note_idx, busy, done, underrun
  );

  modport slave (
    output start, pause, beat_tick, rom_note,
    input  rom_addr, note_out, note_valid, note_idx, busy, done, underrun
  );
endinterface

// File: rtl/note_sequencer.sv
// Walks the note ROM from address 0, holds each note and emits it as a one-cycle pulse on the beat.
// Stops at END_MARKER or after MAX_ADDR; ticks arriving mid-fetch are dropped and flagged.
module note_sequencer #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] END_MARKER = 4'b1111,
  parameter int                    MAX_ADDR   = 63
) (
  input  logic                  clk,
  input  logic                  rst,
  note_sequencer_if.master      bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] READY   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = MAX_ADDR[ADDR_WIDTH-1:0];

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] note_buf;
  logic [DATA_WIDTH-1:0] note_out;
  logic [ADDR_WIDTH-1:0] note_idx;
  logic                  note_valid;
  logic                  underrun;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      note_buf   <= '0;
      note_out   <= '0;
      note_idx   <= '0;
      note_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      case (state)
        IDLE: begin
          addr <= '0;
          if (bus.start) begin
            state    <= FETCH;
            underrun <= 1'b0;
          end
        end
        FETCH: begin
          state <= CAPTURE;
          if (bus.beat_tick) underrun <= 1'b1;
        end
        CAPTURE: begin
          // rom_note is the registered read of the address presented during FETCH.
          note_buf <= bus.rom_note;
          state    <= (bus.rom_note == END_MARKER) ? DONE : READY;
          if (bus.beat_tick) underrun <= 1'b1;
        end
        READY: begin
          if (bus.beat_tick && !bus.pause) begin
            // A zero note is a rest: it uses up the beat but shows nothing.
            if (note_buf != '0) begin
              note_valid <= 1'b1;
              note_out   <= note_buf;
              note_idx   <= addr;
            end
            if (addr == LAST_ADDR) begin
              state <= DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= FETCH;
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            addr     <= '0;
            state    <= FETCH;
            underrun <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = addr;
  assign bus.note_out   = note_out;
  assign bus.note_valid = note_valid;
  assign bus.note_idx   = note_idx;
  assign bus.underrun   = underrun;
  assign bus.busy       = (state == FETCH) || (state == CAPTURE) || (state == READY);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench: ROM model with registered read, expected notes queued when each beat is driven.
module tb_note_sequencer;

  typedef struct {
    logic [3:0] note;
    logic [5:0] idx;
  } exp_t;

  logic clk;
  logic rst;
  logic [3:0] rom [64];
  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  logic prev_valid = 1'b0;

  note_sequencer_if #(.ADDR_WIDTH(6), .DATA_WIDTH(4)) bus ();

  note_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Note ROM: one-cycle registered read, cleared by the shared reset.
  always @(posedge clk) begin
    if (!rst) bus.rom_note <= 4'd0;
    else      bus.rom_note <= rom[bus.rom_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.note_valid === 1'b1) begin
      exp_t e;
      pulses++;
      chk("double_pulse", {31'd0, prev_valid}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, bus.note_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("note_out", {28'd0, bus.note_out}, {28'd0, e.note});
        chk("note_idx", {26'd0, bus.note_idx}, {26'd0, e.idx});
      end
    end
    prev_valid = bus.note_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Drive one beat; when emit is set the resulting pulse is expected.
  task automatic beat(input bit emit, input logic [3:0] note, input logic [5:0] idx);
    exp_t e;
    if (emit) begin
      e.note = note;
      e.idx  = idx;
      sb.push_back(e);
    end
    bus.beat_tick = 1'b1;
    @(negedge clk);
    bus.beat_tick = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    for (int i = 0; i < 64; i++) rom[i] = 4'hF;
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rom_addr"}, {26'd0, bus.rom_addr}, 32'd0);
    chk({tag, "_note_out"}, {28'd0, bus.note_out}, 32'd0);
    chk({tag, "_note_idx"}, {26'd0, bus.note_idx}, 32'd0);
    chk({tag, "_note_valid"}, {31'd0, bus.note_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_underrun"}, {31'd0, bus.underrun}, 32'd0);
  endtask

  initial begin
    int p0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.beat_tick = 1'b0;
    load(4'h1, 4'h1, 4'h8, 4'hF);

    // Reset state
    cyc(2);
    chk_all_zero("reset");
    rst = 1'b1;
    cyc(1);

    // Normal level: 1,1,8 then marker
    do_start();
    for (int i = 0; i < 3; i++) begin
      cyc(9);
      beat(1'b1, rom[i], 6'(i));
    end
    cyc(1);
    chk("done_early", {31'd0, bus.done}, 32'd0);
    cyc(1);
    chk("done_after_marker", {31'd0, bus.done}, 32'd1);
    chk("busy_in_done", {31'd0, bus.busy}, 32'd0);
    chk("addr_at_marker", {26'd0, bus.rom_addr}, 32'd3);
    cyc(3);
    beat(1'b0, 4'h0, 6'd0);
    cyc(3);
    chk("normal_queue_empty", sb.size(), 32'd0);

    // Pause holds the note across a beat
    do_start();
    cyc(9);
    bus.pause = 1'b1;
    beat(1'b0, 4'h0, 6'd0);
    cyc(2);
    chk("pause_addr_held", {26'd0, bus.rom_addr}, 32'd0);
    chk("pause_no_underrun", {31'd0, bus.underrun}, 32'd0);
    bus.pause = 1'b0;
    cyc(3);
    beat(1'b1, 4'h1, 6'd0);
    chk("addr_after_emit", {26'd0, bus.rom_addr}, 32'd1);
    cyc(9);
    beat(1'b1, 4'h1, 6'd1);
    cyc(9);
    beat(1'b1, 4'h8, 6'd2);
    cyc(5);
    chk("pause_done", {31'd0, bus.done}, 32'd1);

    // Underrun and rest
    load(4'h4, 4'h0, 4'h2, 4'hF);
    do_start();
    cyc(9);
    beat(1'b1, 4'h4, 6'd0);
    beat(1'b0, 4'h0, 6'd0);
    chk("underrun_set", {31'd0, bus.underrun}, 32'd1);
    cyc(9);
    beat(1'b0, 4'h0, 6'd1);
    cyc(2);
    chk("rest_note_held", {28'd0, bus.note_out}, 32'h4);
    chk("rest_idx_held", {26'd0, bus.note_idx}, 32'd0);
    cyc(7);
    beat(1'b1, 4'h2, 6'd2);
    cyc(5);
    chk("underrun_done", {31'd0, bus.done}, 32'd1);
    chk("underrun_sticky", {31'd0, bus.underrun}, 32'd1);

    // Restart with start and beat together in DONE
    bus.start = 1'b1;
    bus.beat_tick = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.beat_tick = 1'b0;
    chk("restart_busy", {31'd0, bus.busy}, 32'd1);
    chk("restart_done", {31'd0, bus.done}, 32'd0);
    chk("restart_underrun", {31'd0, bus.underrun}, 32'd0);
    chk("restart_addr", {26'd0, bus.rom_addr}, 32'd0);
    cyc(3);
    beat(1'b1, 4'h4, 6'd0);

    // Mid-stream reset, then replay from address 0
    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk_all_zero("midreset");
    cyc(1);
    rst = 1'b1;
    do_start();
    cyc(9);
    beat(1'b1, 4'h4, 6'd0);
    cyc(9);
    beat(1'b0, 4'h0, 6'd1);
    cyc(9);
    beat(1'b1, 4'h2, 6'd2);
    cyc(5);
    chk("replay_done", {31'd0, bus.done}, 32'd1);

    // No marker: 64 notes then forced end
    for (int i = 0; i < 64; i++) rom[i] = 4'h1;
    p0 = pulses;
    do_start();
    for (int i = 0; i < 64; i++) begin
      cyc(3);
      chk("nomark_addr", {26'd0, bus.rom_addr}, i);
      beat(1'b1, 4'h1, 6'(i));
    end
    chk("nomark_done", {31'd0, bus.done}, 32'd1);
    chk("nomark_last_addr", {26'd0, bus.rom_addr}, 32'd63);
    cyc(3);
    chk("nomark_pulses", pulses - p0, 32'd64);
    chk("final_queue_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Reader side of the level note ROM.
- Walks ROM addresses from 0, absorbs the ROM's one-cycle registered read latency, and holds each fetched note until the next beat tick.
- On the beat it emits the note to the arrow scroller as a one-cycle valid pulse.
- Stops at the end-of-level marker, or at the last address if no marker is present.

Parameters:
- ADDR_WIDTH, 6, ROM address width.
- DATA_WIDTH, 4, note width; one bit per arrow lane.
- END_MARKER, 4'b1111, note value that terminates the level; never emitted.
- MAX_ADDR, 63, last legal address; forced end if reached without a marker.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low (rst=0 resets).
- start  in  1  begin or restart the level; honoured only in IDLE or DONE.
- pause  in  1  while high, beat ticks are not consumed.
- beat_tick  in  1  one-cycle pulse per song beat.
- rom_addr  out  ADDR_WIDTH  address to the note ROM; registered.
- rom_note  in  DATA_WIDTH  ROM data, valid the cycle after rom_addr is presented.
- note_out  out  DATA_WIDTH  emitted note; held until the next emit.
- note_valid  out  1  one-cycle pulse, note_out is new.
- note_idx  out  ADDR_WIDTH  ROM address of the note on note_out.
- busy  out  1  high in FETCH, CAPTURE and READY.
- done  out  1  high in DONE.
- underrun  out  1  sticky; a beat_tick was lost.

Behaviour:
- Reset (rst=0 at a clk edge), effective at that edge from any state:
  - state goes to IDLE.
  - rom_addr, note_out, note_idx, note_buf, note_valid, busy, done and underrun all go to 0.
- IDLE: rom_addr=0. start=1 -> FETCH with addr=0; underrun cleared.
- FETCH (1 cycle): rom_addr holds addr. Next state is CAPTURE.
- CAPTURE (1 cycle): sample rom_note into note_buf.
  - rom_note==END_MARKER -> DONE.
  - Otherwise -> READY.
- READY: wait for beat_tick=1 with pause=0. On that edge:
  - Registered outputs: note_valid=1 next cycle only, note_out=note_buf, note_idx=addr.
  - Exception: if note_buf==0 (rest), note_valid stays 0 and note_out/note_idx keep their old values. The beat is still consumed.
  - If addr==MAX_ADDR -> DONE. Otherwise addr<=addr+1 (no wrap) -> FETCH.
- DONE: done=1, busy=0, rom_addr holds its last value. start=1 -> FETCH with addr=0, done=0, underrun cleared.
- Latency:
  - beat_tick accepted at edge n -> note_valid high in cycle n+1.
  - Next FETCH begins in cycle n+1; the next note reaches READY 2 cycles later.
- beat_tick handling outside READY:
  - In FETCH or CAPTURE: the tick is dropped and underrun<=1 (sticky).
  - In IDLE, DONE, or READY with pause=1: the tick is ignored; underrun is not set.
- start while busy is ignored.
- start and beat_tick in the same cycle in DONE: start wins, the tick is ignored.
- pause has no effect in FETCH or CAPTURE; fetching continues and the block parks in READY.
- note_valid is never high for two consecutive cycles.
- The ROM's own reset is driven externally. A zero read caused by ROM reset is treated as a rest.

Test Plan:
- Reset: hold rst=0 for 2 cycles mid-stream -> all outputs 0 and rom_addr=0 at the following edge. start then replays from addr 0.
- Normal level: ROM model {0001,0001,1000,1111}, start, beat_tick every 10 cycles.
  - Expect 3 note_valid pulses with note_out 1,1,8 and note_idx 0,1,2, each one cycle after its tick.
  - done=1 two cycles after the third pulse; no 4th pulse.
- Pause: pause=1 across one beat_tick while in READY -> no pulse and addr unchanged. Drop pause; next tick emits the held note.
- Underrun and rest: ROM {0100,0000,0010,1111}.
  - Tick again the cycle after the first emit (FETCH) -> underrun=1 and still only one pulse (0100).
  - The rest consumes the next tick with no pulse; the following tick emits 0010 with idx 2.
- No marker: ROM all 0001 for 64 entries -> 64 pulses, note_idx 0..63, then done=1. rom_addr never wraps to 0 before DONE.
- Restart: in DONE, assert start together with beat_tick -> FETCH at addr 0, no pulse, underrun=0.
